prbs_ca16_checker: RTL and testbench

//  Receive-side checker for the 16-bit hybrid rule-90/150 cellular-automaton PRNG stream.

---
 rtl/prbs_ca16_pkg.sv | 27 ++
 rtl/prbs_ca16_checker_if.sv | 23 ++
 rtl/prbs_ca16_popcnt.sv | 15 +
 rtl/prbs_ca16_checker.sv | 162 ++++++++++++++++
 tb/tb_prbs_ca16_checker.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/prbs_ca16_pkg.sv
// rtl/prbs_ca16_pkg.sv - shared CA constants, FSM state type and CA helper functions
package prbs_ca16_pkg;

  localparam logic [15:0] CA_MASK = 16'hDB6D;
  localparam logic [15:0] CA_SEED = 16'h00A3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ca_state_e;

  // One step of the hybrid rule-90/150 CA; zeros enter at both ends.
  function automatic logic [15:0] ca_next(input logic [15:0] s);
    return (s << 1) ^ (s >> 1) ^ (s & CA_MASK);
  endfunction

  // Wire order is MSB = cell 0, so the line word is the CA state reversed.
  function automatic logic [15:0] bitrev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = w[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_ca16_checker_if.sv
// rtl/prbs_ca16_checker_if.sv - stream input and status/counter outputs of the checker
interface prbs_ca16_checker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic [15:0]      in_data;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_err;

  modport master (
    output in_valid, in_data, clr_cnt,
    input  locked, err_pulse, word_cnt, err_cnt, bit_err
  );

  modport slave (
    input  in_valid, in_data, clr_cnt,
    output locked, err_pulse, word_cnt, err_cnt, bit_err
  );
endinterface

// File: rtl/prbs_ca16_popcnt.sv
// rtl/prbs_ca16_popcnt.sv - 16-bit ones count for per-bit error accounting
module prbs_ca16_popcnt (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);

  // Straight adder chain; 16 inputs fit a 5-bit result.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_data[i]};
    end
  end

endmodule

// File: rtl/prbs_ca16_checker.sv
// rtl/prbs_ca16_checker.sv - self-synchronising CA16 PRBS checker; PRBS_CHK_BITERR_EN enables bit-error count
module prbs_ca16_checker
  import prbs_ca16_pkg::*;
#(
  parameter int unsigned SYNC_CNT = 2,
  parameter int unsigned LOSS_CNT = 4,
  parameter int unsigned CNT_W    = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  prbs_ca16_checker_if.slave   bus
);

  localparam logic [3:0]       LP_SYNC = 4'(SYNC_CNT);
  localparam logic [3:0]       LP_LOSS = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  ca_state_e        r_state, w_state_nxt;
  logic [15:0]      r_expected, w_expected_nxt;
  logic [3:0]       r_match, w_match_nxt;
  logic [3:0]       r_miss, w_miss_nxt;
  logic             w_word_evt, w_err_evt;
  logic [15:0]      w_rx;
  logic             w_hit;
  logic [3:0]       w_match_inc, w_miss_inc;
  logic [CNT_W-1:0] r_word_cnt, r_err_cnt;
  logic             r_err_pulse;

  assign w_rx        = bitrev16(bus.in_data);
  assign w_hit       = (w_rx == r_expected);
  assign w_match_inc = r_match + 4'd1;
  assign w_miss_inc  = r_miss + 4'd1;

  // FSM and predictor registers; only valid words move them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_expected <= '0;
      r_match    <= '0;
      r_miss     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
      r_match    <= w_match_nxt;
      r_miss     <= w_miss_nxt;
    end
  end

  // Next state: seed/verify in HUNT/VERIFY, free-running flywheel in LOCKED.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_match_nxt    = r_match;
    w_miss_nxt     = r_miss;
    w_word_evt     = 1'b0;
    w_err_evt      = 1'b0;
    if (bus.in_valid) begin
      case (r_state)
        HUNT: begin
          if (w_rx != '0) begin
            w_expected_nxt = ca_next(w_rx);
            w_state_nxt    = VERIFY;
            w_match_nxt    = '0;
          end
        end
        VERIFY: begin
          if (w_hit) begin
            w_match_nxt    = w_match_inc;
            w_expected_nxt = ca_next(r_expected);
            if (w_match_inc == LP_SYNC) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else if (w_rx != '0) begin
            w_expected_nxt = ca_next(w_rx);
            w_match_nxt    = '0;
          end else begin
            w_state_nxt = HUNT;
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          w_expected_nxt = ca_next(r_expected);
          w_word_evt     = 1'b1;
          if (w_hit) begin
            w_miss_nxt = '0;
          end else begin
            w_err_evt  = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == LP_LOSS) begin
              w_state_nxt = HUNT;
              w_miss_nxt  = '0;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  // Saturating word/error counters; clear has priority over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err_evt;
      if (bus.clr_cnt) begin
        r_word_cnt <= '0;
        r_err_cnt  <= '0;
      end else begin
        if (w_word_evt && (r_word_cnt != '1)) begin
          r_word_cnt <= r_word_cnt + LP_ONE;
        end
        if (w_err_evt && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + LP_ONE;
        end
      end
    end
  end

  assign bus.locked    = (r_state == LOCKED);
  assign bus.err_pulse = r_err_pulse;
  assign bus.word_cnt  = r_word_cnt;
  assign bus.err_cnt   = r_err_cnt;

`ifdef PRBS_CHK_BITERR_EN
  localparam int unsigned LP_SUM_W = CNT_W + 1;

  logic [15:0]         w_diff;
  logic [4:0]          w_pop;
  logic [LP_SUM_W-1:0] w_bit_sum;
  logic [CNT_W-1:0]    r_bit_err;

  assign w_diff    = w_rx ^ r_expected;
  assign w_bit_sum = {1'b0, r_bit_err} + LP_SUM_W'(w_pop);

  prbs_ca16_popcnt u_popcnt (
    .i_data  (w_diff),
    .o_count (w_pop)
  );

  // Bit-error accumulator clamps at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_err <= '0;
    end else if (bus.clr_cnt) begin
      r_bit_err <= '0;
    end else if (w_word_evt) begin
      r_bit_err <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
    end
  end

  assign bus.bit_err = r_bit_err;
`else
  assign bus.bit_err = '0;
`endif

endmodule

// File: tb/tb_prbs_ca16_checker.sv
// tb/tb_prbs_ca16_checker.sv - directed vector bench for prbs_ca16_checker; honours PRBS_CHK_BITERR_EN
module tb_prbs_ca16_checker;

  logic clk;
  logic rst_n;

  prbs_ca16_checker_if #(.CNT_W(32)) bus ();

  prbs_ca16_checker #(
    .SYNC_CNT (2),
    .LOSS_CNT (4),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        clr;
    logic        locked;
    logic        err;
    int          wc;
    int          ec;
    int          bits;
  } vec_t;

  vec_t        tbl[$];
  int          n_checks;
  int          n_fail;
  logic [15:0] g;
  int          bits;

  function automatic logic [15:0] tb_rev(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = w[i];
    return r;
  endfunction

  function automatic logic [15:0] tb_next(input logic [15:0] s);
    logic [15:0] m;
    logic [15:0] n;
    logic        lo, hi;
    m = 16'hDB6D;
    for (int i = 0; i < 16; i++) begin
      lo   = (i > 0)  ? s[i-1] : 1'b0;
      hi   = (i < 15) ? s[i+1] : 1'b0;
      n[i] = lo ^ hi ^ (m[i] & s[i]);
    end
    return n;
  endfunction

  task automatic gen(output logic [15:0] w);
    g = tb_next(g);
    w = tb_rev(g);
  endtask

  task automatic add(input logic v, input logic [15:0] d, input logic c, input logic l,
                     input logic e, input int wc, input int ec, input int b);
    vec_t x;
    x.v = v; x.d = d; x.clr = c; x.locked = l; x.err = e; x.wc = wc; x.ec = ec; x.bits = b;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic l, input int wc, input int ec, input int b);
    chk({nm, "_locked"}, 64'(bus.locked), 64'(l));
    chk({nm, "_word_cnt"}, 64'(bus.word_cnt), 64'(wc));
    chk({nm, "_err_cnt"}, 64'(bus.err_cnt), 64'(ec));
`ifdef PRBS_CHK_BITERR_EN
    chk({nm, "_bit_err"}, 64'(bus.bit_err), 64'(b));
`else
    chk({nm, "_bit_err"}, 64'(bus.bit_err), 64'(b * 0));
`endif
  endtask

  initial begin
    logic [15:0] w;
    n_checks = 0;
    n_fail   = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clr_cnt  = 1'b0;

    // vector table: lock, single corruption, gaps, loss of lock, relock
    g = 16'h00A3;
    bits = 0;
    g = tb_next(g); add(1, 16'h6C80, 0, 0, 0, 0, 0, bits);
    g = tb_next(g); add(1, 16'hCBC0, 0, 0, 0, 0, 0, bits);
    gen(w); add(1, w, 0, 1, 0, 0, 0, bits);
    gen(w); add(1, w, 0, 1, 0, 1, 0, bits);
    gen(w); bits += 1; add(1, w ^ 16'h0001, 0, 1, 1, 2, 1, bits);
    gen(w); add(1, w, 0, 1, 0, 3, 1, bits);
    gen(w); add(1, w, 0, 1, 0, 4, 1, bits);
    add(0, 16'h1234, 0, 1, 0, 4, 1, bits);
    add(0, 16'hFFFF, 0, 1, 0, 4, 1, bits);
    gen(w); add(1, w, 0, 1, 0, 5, 1, bits);
    add(0, 16'h0000, 0, 1, 0, 5, 1, bits);
    gen(w); add(1, w, 0, 1, 0, 6, 1, bits);
    for (int k = 0; k < 4; k++) begin
      gen(w);
      bits += $countones(~g);
      add(1, 16'hFFFF, 0, (k < 3) ? 1'b1 : 1'b0, 1, 7 + k, 2 + k, bits);
    end
    gen(w); add(1, w, 0, 0, 0, 10, 5, bits);
    gen(w); add(1, w, 0, 0, 0, 10, 5, bits);
    gen(w); add(1, w, 0, 1, 0, 10, 5, bits);
    gen(w); add(1, w, 0, 1, 0, 11, 5, bits);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0);
    chk("reset_err_pulse", 64'(bus.err_pulse), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].locked, tbl[i].wc, tbl[i].ec, tbl[i].bits);
      chk($sformatf("vec%0d_err_pulse", i), 64'(bus.err_pulse), 64'(tbl[i].err));
    end

    // clear coincident with a corrupted word: clear wins
    gen(w); step(1, w ^ 16'h0001, 1);
    chk_all("clr_evt", 1, 0, 0, 0);
    gen(w); step(1, w, 0);
    chk_all("post_clr", 1, 1, 0, 0);
    chk("post_clr_err_pulse", 64'(bus.err_pulse), 64'd0);
    gen(w); step(1, w ^ 16'h0001, 0);
    chk_all("corrupt2", 1, 2, 1, 1);
    chk("corrupt2_err_pulse", 64'(bus.err_pulse), 64'd1);
    gen(w); step(1, w, 0);
    chk_all("flywheel2", 1, 3, 1, 1);
    chk("flywheel2_err_pulse", 64'(bus.err_pulse), 64'd0);

    // asynchronous reset mid-lock, then fresh relock
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_all("async_rst", 0, 0, 0, 0);
    chk("async_rst_err_pulse", 64'(bus.err_pulse), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gen(w); step(1, w, 0);
    chk("relock1", 64'(bus.locked), 64'd0);
    gen(w); step(1, w, 0);
    chk("relock2", 64'(bus.locked), 64'd0);
    gen(w); step(1, w, 0);
    chk("relock3", 64'(bus.locked), 64'd1);
    gen(w); step(1, w, 0);
    chk_all("relock4", 1, 1, 0, 0);
    step(0, 16'h0000, 1);
    chk_all("clr_idle", 1, 0, 0, 0);

    // all-zero words are rejected in HUNT; a VERIFY mismatch reseeds
    rst_n = 1'b0;
    step(0, 16'h0000, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1, 16'h0000, 0);
      chk_all($sformatf("zero%0d", k), 0, 0, 0, 0);
    end
    gen(w); step(1, w, 0);
    chk("seed_x", 64'(bus.locked), 64'd0);
    gen(w);
    gen(w); step(1, w, 0);
    chk("reseed_y", 64'(bus.locked), 64'd0);
    gen(w); step(1, w, 0);
    chk("match_z", 64'(bus.locked), 64'd0);
    gen(w); step(1, w, 0);
    chk("lock_q", 64'(bus.locked), 64'd1);
    step(0, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
